// File: rtl/uart_pkg.sv
// Shared UART constants: arbiter FSM encoding and frame timing used by the TX/RX blocks.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] START = 2'b01;
    localparam logic [1:0] WAIT  = 2'b10;

    localparam int FRAME_BITS = 10;
    localparam int OVERSAMPLE = 16;

    // Slack on top of one full oversampled frame before tx_done is considered lost.
    localparam int TIMEOUT_MARGIN  = 40;
    localparam int DEFAULT_TIMEOUT = FRAME_BITS * OVERSAMPLE + TIMEOUT_MARGIN;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first set bit of req at or above ptr, wrapping past the top.
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               found,
    output logic [IW-1:0]      idx
);

    int j;

    // Walk offsets from the far end down so the smallest offset from ptr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte sources,
// with per-requester ack on tx_done and err when the frame never completes.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 8,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                          tx_clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*data_width-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            err,
    output logic                          tx_start,
    output logic [data_width-1:0]         tx_data,
    input  logic                          tx_busy,
    input  logic                          tx_done,
    output logic                          busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] idx;
    logic [15:0]   cnt;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] next_ptr;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign next_ptr = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    assign tx_start = (state == START);
    assign busy     = (state != IDLE);

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            idx     <= '0;
            cnt     <= '0;
            grant   <= '0;
            ack     <= '0;
            err     <= '0;
            tx_data <= '0;
        end else begin
            ack <= '0;
            err <= '0;
            case (state)
                IDLE: begin
                    // A busy transmitter means someone else owns the line; stay out of it.
                    if (pick_found && !tx_busy) begin
                        grant   <= NUM_REQ'(1) << pick_idx;
                        idx     <= pick_idx;
                        tx_data <= req_data[pick_idx*data_width +: data_width];
                        state   <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (tx_done) begin
                        ack   <= NUM_REQ'(1) << idx;
                        ptr   <= next_ptr;
                        grant <= '0;
                        state <= IDLE;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        err   <= NUM_REQ'(1) << idx;
                        ptr   <= next_ptr;
                        grant <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default-timeout instance for arbitration,
// a TIMEOUT=8 instance for the timeout and tx_done/timeout collision cases.
module tb_uart_tx_arbiter;

    logic        tx_clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant, ack, err;
    logic        tx_start, tx_busy, tx_done, busy;
    logic [7:0]  tx_data;

    logic [3:0]  t_req;
    logic [31:0] t_req_data;
    logic [3:0]  t_grant, t_ack, t_err;
    logic        t_start, t_busy_in, t_done, t_busy;
    logic [7:0]  t_data;

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int base;
    logic [7:0] bytes [4];

    always #5 tx_clk = ~tx_clk;

    always @(posedge tx_clk) if (tx_start) starts++;

    uart_tx_arbiter dut (
        .tx_clk   (tx_clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .ack      (ack),
        .err      (err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    uart_tx_arbiter #(.TIMEOUT(8)) dut_to (
        .tx_clk   (tx_clk),
        .rst      (rst),
        .req      (t_req),
        .req_data (t_req_data),
        .grant    (t_grant),
        .ack      (t_ack),
        .err      (t_err),
        .tx_start (t_start),
        .tx_data  (t_data),
        .tx_busy  (t_busy_in),
        .tx_done  (t_done),
        .busy     (t_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge tx_clk);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = 32'h44A52211; tx_busy = 1'b0; tx_done = 1'b0;
        t_req = '0; t_req_data = 32'h0000BB00; t_busy_in = 1'b0; t_done = 1'b0;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'hA5; bytes[3] = 8'h44;

        step(); step();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_ack_err", {ack, err}, 0);
        rst = 1'b0;

        // single request on requester 2
        base = starts;
        req = 4'b0100;
        step();
        chk("single_grant", grant, 4'b0100);
        chk("single_data", tx_data, 8'hA5);
        chk("single_start", tx_start, 1);
        chk("single_busy", busy, 1);
        req = '0;
        repeat (20) step();
        chk("single_ack_early", ack, 0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("single_ack", ack, 4'b0100);
        chk("single_err", err, 0);
        chk("single_busy_after", busy, 0);
        step();
        chk("single_ack_pulse", ack, 0);
        chk("single_starts", starts - base, 1);

        // round robin from ptr=0 with all requesters pending
        rst = 1'b1; step(); rst = 1'b0;
        base = starts;
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            step();
            chk($sformatf("rr_grant%0d", f), grant, 32'(4'b0001 << (f % 4)));
            chk($sformatf("rr_data%0d", f), tx_data, bytes[f % 4]);
            repeat (3) step();
            tx_done = 1'b1;
            if (f == 4) req = '0;
            step();
            tx_done = 1'b0;
            chk($sformatf("rr_ack%0d", f), ack, 32'(4'b0001 << (f % 4)));
            if (f == 3) chk("rr_starts4", starts - base, 4);
        end
        chk("rr_starts5", starts - base, 5);

        // busy blocking, ptr=1
        tx_busy = 1'b1;
        req = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("blk_grant", grant, 0);
            chk("blk_start", tx_start, 0);
        end
        tx_busy = 1'b0;
        step();
        chk("blk_grant_after", grant, 4'b0010);
        chk("blk_data", tx_data, 8'h22);
        req = '0;
        repeat (2) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("blk_ack", ack, 4'b0010);

        // mid-frame reset with ptr=2
        req = 4'b1000;
        step();
        chk("mrst_grant", grant, 4'b1000);
        req = '0;
        repeat (3) step();
        #1 rst = 1'b1;
        #1;
        chk("mrst_grant0", grant, 0);
        chk("mrst_start0", tx_start, 0);
        chk("mrst_busy0", busy, 0);
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst_no_ack_err", {ack, err}, 0);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("idle_done_ignored", ack, 0);
        req = 4'b0110;
        step();
        chk("mrst_first_grant", grant, 4'b0010);
        req = '0;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("mrst_ack", ack, 4'b0010);

        // timeout on the TIMEOUT=8 instance
        t_req = 4'b0001;
        step();
        chk("to_grant", t_grant, 4'b0001);
        chk("to_start", t_start, 1);
        t_req = '0;
        repeat (8) step();
        chk("to_err_early", t_err, 0);
        step();
        chk("to_err", t_err, 4'b0001);
        chk("to_no_ack", t_ack, 0);
        step();
        chk("to_err_pulse", t_err, 0);
        chk("to_busy", t_busy, 0);
        t_req = 4'b0011;
        step();
        chk("to_next_grant", t_grant, 4'b0010);
        chk("to_next_data", t_data, 8'hBB);
        t_req = '0;

        // tx_done on the same cycle the timeout expires
        repeat (8) step();
        t_done = 1'b1;
        step();
        t_done = 1'b0;
        chk("col_ack", t_ack, 4'b0010);
        chk("col_err", t_err, 0);
        step();
        chk("col_busy", t_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmitter between NUM_REQ independent byte sources using round-robin arbitration. The block captures the winning requester's byte and issues a one-cycle start pulse to the transmitter. It then waits for frame completion and returns a per-requester ack, or an err if the transmitter never completes. It sits between the client logic and the UART transmit datapath, in the same clock domain as that datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
data_width, 8, bits per UART character.
TIMEOUT, 200, number of WAIT-state cycles allowed before tx_done is declared missing (1..65535).

Ports:
tx_clk  in  1  block clock, same clock as the UART transmitter.
rst  in  1  asynchronous, active-high reset.
req  in  NUM_REQ  per-requester transmit request, level signal.
req_data  in  NUM_REQ*data_width  flattened bytes; requester i uses bits [i*data_width +: data_width].
grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
ack  out  NUM_REQ  one-cycle pulse to the owner when its frame completes.
err  out  NUM_REQ  one-cycle pulse to the owner on timeout.
tx_start  out  1  one-cycle start pulse to the transmitter.
tx_data  out  data_width  captured byte; held stable from START through WAIT.
tx_busy  in  1  transmitter is sending a frame.
tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, ptr=0, grant=0, ack=0, err=0, tx_start=0, tx_data=0, busy=0, timeout counter=0.
- FSM encoding: IDLE=2'b00, START=2'b01, WAIT=2'b10, unused 2'b11 returns to IDLE.
- IDLE, when |req and !tx_busy:
  - Pick the first asserted req searching upward from ptr, wrapping modulo NUM_REQ.
  - Register grant = one-hot of the winner, idx = winner, tx_data = that requester's byte.
  - Next state is START.
- IDLE, when tx_busy=1: no arbitration takes place, so any foreign in-flight frame is respected.
- START: tx_start=1 for exactly this one cycle, decoded from the state register. Timeout counter is cleared. Next state is WAIT.
- WAIT: the counter increments once per cycle.
  - If tx_done=1: ack[idx]=1 for one cycle; ptr = (idx+1) mod NUM_REQ; grant=0; state goes to IDLE.
  - Else if counter == TIMEOUT-1: err[idx]=1 for one cycle; ptr advances as above; grant=0; state goes to IDLE.
  - If tx_done and the timeout occur in the same cycle, tx_done wins: ack is pulsed, err is not.
- Latency: req is sampled at edge k; grant and tx_data are valid after edge k; tx_start is high between edges k and k+1.
  - ack/err are registered and appear the cycle after the edge that samples tx_done or the timeout.
  - A new grant can appear at the earliest 1 cycle after ack.
- Requester rules:
  - req_data must be stable while req=1 and the requester is not yet granted.
  - Deasserting req after grant does not abort the frame, because the byte is already captured; ack/err is still pulsed.
  - A requester that keeps req high after ack is re-arbitrated. It does not win again ahead of other pending requesters.
- Ignored inputs: tx_done in IDLE or START is ignored. tx_busy is only examined in IDLE.
- Fairness: with all req high, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 frames.
- Widths: ptr and idx are $clog2(NUM_REQ) bits. The counter is 16 bits.
- Reset mid-frame: all outputs return to their reset values immediately. No ack or err is generated for the aborted frame.

Decomposition:
- Package uart_pkg holds:
  - the FSM state localparams (IDLE/START/WAIT);
  - FRAME_BITS=10 and OVERSAMPLE=16, shared with the receiver and transmitter;
  - the helper constant used to derive a TIMEOUT default (FRAME_BITS*OVERSAMPLE + margin).
- One combinational sub-module, uart_rr_pick: inputs req and ptr; outputs found and idx of the first set bit at or above ptr with wrap. It is reused by future UART mux blocks.

Test Plan:
- Single request: req=4'b0100, req_data[23:16]=8'hA5, tx_done pulsed 20 cycles after tx_start. Required: grant=4'b0100 and tx_data=8'hA5 one cycle after req; exactly one tx_start; ack=4'b0100 one cycle after tx_done; busy=0 afterwards.
- Round-robin: req=4'b1111 held, each frame completed with tx_done. Required: grant sequence 0001, 0010, 0100, 1000, 0001, with exactly 4 tx_start pulses per cycle through all requesters.
- Timeout: TIMEOUT=8, req=4'b0001, tx_done never pulsed. Required: err=4'b0001 exactly 8 WAIT cycles after START; no ack; ptr=1, so the next grant with req=4'b0011 goes to requester 1.
- Collision: tx_done and the timeout occur in the same cycle. Required: ack pulsed, err stays 0.
- Busy blocking: tx_busy=1 while req=4'b0010. Required: no grant and no tx_start until tx_busy falls; grant appears 1 cycle later.
- Mid-frame reset: rst asserted in WAIT. Required: grant=0, tx_start=0, busy=0 in the same cycle; no ack/err after release; the first grant after release goes to the lowest asserted req, since ptr=0.
